// File: rtl/multi_channel_delay_monitor.sv
// Per-channel event1->event2 delay monitor: measures cycles between rising edges,
// flags measurements shorter than min_limit and arms that time out at max_limit.
module multi_channel_delay_monitor #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int ERR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [CHANNELS-1:0]             event1,
  input  logic [CHANNELS-1:0]             event2,
  input  logic [CNT_WIDTH-1:0]            min_limit,
  input  logic [CNT_WIDTH-1:0]            max_limit,
  output logic [CHANNELS-1:0]             busy,
  output logic [CHANNELS-1:0]             too_early,
  output logic [CHANNELS-1:0]             too_late,
  output logic [CHANNELS*CNT_WIDTH-1:0]   last_delay,
  output logic [CHANNELS*ERR_WIDTH-1:0]   err_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  logic min_on;
  logic max_on;

  assign min_on = (min_limit != '0);
  assign max_on = (max_limit != '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   count, count_nxt;
    logic [CNT_WIDTH-1:0]   last_q, last_nxt;
    logic [ERR_WIDTH-1:0]   err_q, err_nxt, err_base;
    logic                   early_q, early_nxt;
    logic                   late_q, late_nxt;
    logic                   e1_q, e2_q;
    logic                   rise1, rise2;
    logic                   violation;

    // Edge registers run regardless of enable so re-enabling never fakes a rise.
    assign rise1 = event1[i] & ~e1_q;
    assign rise2 = event2[i] & ~e2_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
      state_nxt = state;
      count_nxt = count;
      last_nxt  = last_q;
      early_nxt = clear ? 1'b0 : early_q;
      late_nxt  = clear ? 1'b0 : late_q;
      err_base  = clear ? '0 : err_q;
      violation = 1'b0;

      if (!enable) begin
        state_nxt = IDLE;
      end else if (state == IDLE) begin
        if (rise1) begin
          state_nxt = ARMED;
          count_nxt = CNT_ONE;
        end
      end else begin
        if (rise2) begin
          // The measurement closes on the old count before any retrigger.
          last_nxt = count;
          if (min_on && (count < min_limit)) begin
            early_nxt = 1'b1;
            violation = 1'b1;
          end
          if (rise1) count_nxt = CNT_ONE;
          else       state_nxt = IDLE;
        end else if (rise1) begin
          count_nxt = CNT_ONE;
        end else if (max_on && (count == max_limit)) begin
          late_nxt  = 1'b1;
          violation = 1'b1;
          state_nxt = IDLE;
        end else if (count != CNT_MAX) begin
          count_nxt = count + CNT_ONE;
        end
      end

      err_nxt = err_base;
      if (violation && (err_base != ERR_MAX)) err_nxt = err_base + ERR_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= IDLE;
        count   <= '0;
        last_q  <= '0;
        err_q   <= '0;
        early_q <= 1'b0;
        late_q  <= 1'b0;
        e1_q    <= 1'b0;
        e2_q    <= 1'b0;
      end else begin
        state   <= state_nxt;
        count   <= count_nxt;
        last_q  <= last_nxt;
        err_q   <= err_nxt;
        early_q <= early_nxt;
        late_q  <= late_nxt;
        e1_q    <= event1[i];
        e2_q    <= event2[i];
      end
    end

    assign busy[i]                              = (state == ARMED);
    assign too_early[i]                         = early_q;
    assign too_late[i]                          = late_q;
    assign last_delay[i*CNT_WIDTH +: CNT_WIDTH] = last_q;
    assign err_count[i*ERR_WIDTH +: ERR_WIDTH]  = err_q;
  end

endmodule

// File: tb/tb_multi_channel_delay_monitor.sv
// Directed bench for multi_channel_delay_monitor: a timestamp-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_multi_channel_delay_monitor;

  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int EW  = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [CH-1:0]     event1 = '0;
  logic [CH-1:0]     event2 = '0;
  logic [CW-1:0]     min_limit = '0;
  logic [CW-1:0]     max_limit = '0;
  logic [CH-1:0]     busy, too_early, too_late;
  logic [CH*CW-1:0]  last_delay;
  logic [CH*EW-1:0]  err_count;

  int checks = 0;
  int failures = 0;

  multi_channel_delay_monitor #(.CHANNELS(CH), .CNT_WIDTH(CW), .ERR_WIDTH(EW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .event1     (event1),
    .event2     (event2),
    .min_limit  (min_limit),
    .max_limit  (max_limit),
    .busy       (busy),
    .too_early  (too_early),
    .too_late   (too_late),
    .last_delay (last_delay),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the cycle number at which each channel armed and
  // derives the delay as a timestamp difference.
  int unsigned cyc = 0;
  bit          m_armed [CH];
  int unsigned m_start [CH];
  bit          m_e1q   [CH];
  bit          m_e2q   [CH];
  int          m_last  [CH];
  bit          m_early [CH];
  bit          m_late  [CH];
  int          m_err   [CH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        m_armed[i] = 0; m_start[i] = 0; m_e1q[i] = 0; m_e2q[i] = 0;
        m_last[i] = 0; m_early[i] = 0; m_late[i] = 0; m_err[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit r1, r2;
        int unsigned d;
        r1 = event1[i] && !m_e1q[i];
        r2 = event2[i] && !m_e2q[i];
        m_e1q[i] = event1[i];
        m_e2q[i] = event2[i];
        if (clear) begin
          m_early[i] = 0; m_late[i] = 0; m_err[i] = 0;
        end
        d = cyc - m_start[i];
        if (d > CMAX) d = CMAX;
        if (!enable) begin
          m_armed[i] = 0;
        end else if (!m_armed[i]) begin
          if (r1) begin m_armed[i] = 1; m_start[i] = cyc; end
        end else if (r2) begin
          m_last[i] = int'(d);
          if (min_limit != 0 && d < min_limit) begin
            m_early[i] = 1;
            m_err[i] = (m_err[i] >= EMAX) ? EMAX : m_err[i] + 1;
          end
          if (r1) m_start[i] = cyc;
          else    m_armed[i] = 0;
        end else if (r1) begin
          m_start[i] = cyc;
        end else if (max_limit != 0 && d == max_limit) begin
          m_late[i] = 1;
          m_err[i] = (m_err[i] >= EMAX) ? EMAX : m_err[i] + 1;
          m_armed[i] = 0;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [CH-1:0]    eb, ee, el;
    logic [CH*CW-1:0] ed;
    logic [CH*EW-1:0] ec;
    for (int i = 0; i < CH; i++) begin
      eb[i] = m_armed[i];
      ee[i] = m_early[i];
      el[i] = m_late[i];
      ed[i*CW +: CW] = CW'(m_last[i]);
      ec[i*EW +: EW] = EW'(m_err[i]);
    end
    check("model_busy", 64'(busy), 64'(eb));
    check("model_too_early", 64'(too_early), 64'(ee));
    check("model_too_late", 64'(too_late), 64'(el));
    check("model_last_delay", 64'(last_delay), 64'(ed));
    check("model_err_count", 64'(err_count), 64'(ec));
  end

  function automatic logic [CW-1:0] ld(input int i);
    return last_delay[i*CW +: CW];
  endfunction

  function automatic logic [EW-1:0] ec(input int i);
    return err_count[i*EW +: EW];
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire1(input logic [CH-1:0] m);
    event1 = event1 | m; step(); event1 = event1 & ~m;
  endtask

  task automatic fire2(input logic [CH-1:0] m);
    event2 = event2 | m; step(); event2 = event2 & ~m;
  endtask

  task automatic fire_both(input logic [CH-1:0] m);
    event1 = event1 | m; event2 = event2 | m; step();
    event1 = event1 & ~m; event2 = event2 & ~m;
  endtask

  initial begin
    step(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_last_delay", 64'(last_delay), 64'd0);
    check("reset_err_count", 64'(err_count), 64'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    min_limit = 16'd3;
    max_limit = 16'd10;
    step();

    // Nominal measurement of 5 cycles on ch0.
    fire1(4'b0001);
    check("ch0_busy_armed", 64'(busy[0]), 64'd1);
    step(4);
    fire2(4'b0001);
    check("ch0_delay5", 64'(ld(0)), 64'd5);
    check("ch0_no_flags", 64'({too_early[0], too_late[0]}), 64'd0);
    check("ch0_err0", 64'(ec(0)), 64'd0);
    check("ch0_busy_done", 64'(busy[0]), 64'd0);

    // Too early on ch1.
    fire1(4'b0010);
    step(1);
    fire2(4'b0010);
    check("ch1_delay2", 64'(ld(1)), 64'd2);
    check("ch1_too_early", 64'(too_early[1]), 64'd1);
    check("ch1_err1", 64'(ec(1)), 64'd1);

    // Timeout on ch2 at max=4, late event2 ignored, then exact-boundary rerun.
    min_limit = 16'd0;
    max_limit = 16'd4;
    fire1(4'b0100);
    step(3);
    check("ch2_busy_before_timeout", 64'(busy[2]), 64'd1);
    step();
    check("ch2_too_late", 64'(too_late[2]), 64'd1);
    check("ch2_idle_after_timeout", 64'(busy[2]), 64'd0);
    step(1);
    fire2(4'b0100);
    check("ch2_last_unchanged", 64'(ld(2)), 64'd0);
    check("ch2_err1", 64'(ec(2)), 64'd1);
    fire1(4'b0100);
    step(3);
    fire2(4'b0100);
    check("ch2_boundary_delay4", 64'(ld(2)), 64'd4);
    check("ch2_boundary_no_new_err", 64'(ec(2)), 64'd1);

    // Error counter saturation on ch3.
    min_limit = 16'd3;
    max_limit = 16'd0;
    for (int k = 0; k < 300; k++) begin
      fire1(4'b1000);
      fire2(4'b1000);
    end
    check("ch3_err_saturated", 64'(ec(3)), 64'd255);
    check("ch3_too_early", 64'(too_early[3]), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_err_count", 64'(err_count), 64'd0);
    check("clear_flags", 64'({too_early, too_late}), 64'd0);

    // Violation in the same cycle as clear counts once after the clear.
    fire1(4'b1000);
    clear = 1'b1; event2[3] = 1'b1;
    step();
    clear = 1'b0; event2[3] = 1'b0;
    check("clear_plus_violation_err", 64'(ec(3)), 64'd1);
    check("clear_plus_violation_flag", 64'(too_early[3]), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;

    // Retrigger on ch0.
    min_limit = 16'd0;
    fire1(4'b0001);
    step(2);
    fire1(4'b0001);
    step(1);
    fire2(4'b0001);
    check("ch0_retrigger_delay2", 64'(ld(0)), 64'd2);

    // Simultaneous rises: arm only in IDLE, measure-then-rearm when ARMED.
    fire_both(4'b0010);
    check("ch1_both_idle_arms", 64'(busy[1]), 64'd1);
    check("ch1_both_idle_no_measure", 64'(ld(1)), 64'd2);
    step(2);
    fire_both(4'b0010);
    check("ch1_both_armed_delay3", 64'(ld(1)), 64'd3);
    check("ch1_both_armed_rearmed", 64'(busy[1]), 64'd1);

    // Enable drop while armed; event1 held across re-enable is not a new rise.
    max_limit = 16'd2;
    fire1(4'b0001);
    enable = 1'b0;
    step();
    check("enable_low_busy", 64'(busy), 64'd0);
    event1[0] = 1'b1;
    step(3);
    enable = 1'b1;
    step();
    check("enable_return_no_rise", 64'(busy[0]), 64'd0);
    check("enable_low_no_late", 64'(too_late), 64'd0);
    event1[0] = 1'b0;
    max_limit = 16'd0;
    step();

    // Asynchronous reset mid-ARMED, event1 held high through release.
    fire1(4'b0001);
    step(2);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_last_delay", 64'(last_delay), 64'd0);
    check("async_reset_flags", 64'({too_early, too_late}), 64'd0);
    check("async_reset_err", 64'(err_count), 64'd0);
    event1[0] = 1'b1;
    step(2);
    reset_n = 1'b1;
    step();
    check("release_armed", 64'(busy[0]), 64'd1);
    event1[0] = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
